// File: rtl/key_debounce_2.sv
// Two-flop synchroniser plus per-key debounce FSM for active-low push-buttons.
// Produces a clean level and one-cycle press, release and long-press pulses per key.
module key_debounce_2 #(
  parameter int KEY_NUM  = 2,
  parameter int CNT_MAX  = 1_000_000,
  parameter int LONG_MAX = 50_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_value,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int DW = $clog2(CNT_MAX + 1);
  localparam int LW = $clog2(LONG_MAX + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    PRESSED    = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  logic [KEY_NUM-1:0] sync1_q;
  logic [KEY_NUM-1:0] key_s_q;

  // Idle level of the pins is high, so the synchroniser resets to released.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync1_q <= '1;
      key_s_q <= '1;
    end else begin
      sync1_q <= key;
      key_s_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < KEY_NUM; gi++) begin : g_key
      state_t        state_q, state_d;
      logic [DW-1:0] dcnt_q, dcnt_d;
      logic [LW-1:0] lcnt_q, lcnt_d;
      logic          value_q, value_d;
      logic          press_q, press_d;
      logic          rel_q, rel_d;
      logic          long_q, long_d;

      always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
          state_q <= IDLE;
          dcnt_q  <= '0;
          lcnt_q  <= '0;
          value_q <= 1'b1;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
          long_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          dcnt_q  <= dcnt_d;
          lcnt_q  <= lcnt_d;
          value_q <= value_d;
          press_q <= press_d;
          rel_q   <= rel_d;
          long_q  <= long_d;
        end
      end

      always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        lcnt_d  = lcnt_q;
        value_d = value_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        case (state_q)
          IDLE: begin
            if (!key_s_q[gi]) begin
              state_d = PRESS_FILT;
              dcnt_d  = '0;
            end
          end
          PRESS_FILT: begin
            if (key_s_q[gi]) begin
              state_d = IDLE;
            end else if (dcnt_q == DW'(CNT_MAX - 1)) begin
              state_d = PRESSED;
              value_d = 1'b0;
              press_d = 1'b1;
              lcnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q + DW'(1);
            end
          end
          PRESSED: begin
            // Saturation at LONG_MAX is what limits key_long to once per press.
            if (lcnt_q != LW'(LONG_MAX)) begin
              lcnt_d = lcnt_q + LW'(1);
              if (lcnt_q == LW'(LONG_MAX - 1)) long_d = 1'b1;
            end
            if (key_s_q[gi]) begin
              state_d = REL_FILT;
              dcnt_d  = '0;
            end
          end
          REL_FILT: begin
            if (!key_s_q[gi]) begin
              state_d = PRESSED;
            end else if (dcnt_q == DW'(CNT_MAX - 1)) begin
              state_d = IDLE;
              value_d = 1'b1;
              rel_d   = 1'b1;
            end else begin
              dcnt_d = dcnt_q + DW'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end

      assign key_value[gi]   = value_q;
      assign key_press[gi]   = press_q;
      assign key_release[gi] = rel_q;
      assign key_long[gi]    = long_q;
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce_2.sv
// Directed bench for key_debounce_2 with a run-length behavioural model checked every cycle.
module tb_key_debounce_2;
  localparam int KEY_NUM  = 2;
  localparam int CNT_MAX  = 5;
  localparam int LONG_MAX = 20;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [1:0] key = 2'b00;
  logic [1:0] key_value, key_press, key_release, key_long;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  key_debounce_2 #(.KEY_NUM(KEY_NUM), .CNT_MAX(CNT_MAX), .LONG_MAX(LONG_MAX)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key        (key),
    .key_value  (key_value),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #10 sys_clk = ~sys_clk;

  // Model: the level flips once the delayed pin has disagreed with it for
  // CNT_MAX+1 consecutive samples; held time counts cycles pressed with no
  // release in progress.
  logic [1:0] m_d1, m_d2, m_val, m_press, m_rel, m_long;
  int m_diff [2];
  int m_held [2];

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      m_d1 <= 2'b11; m_d2 <= 2'b11; m_val <= 2'b11;
      m_press <= 2'b00; m_rel <= 2'b00; m_long <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        m_diff[i] <= 0;
        m_held[i] <= 0;
      end
    end else begin
      m_d1 <= key;
      m_d2 <= m_d1;
      for (int i = 0; i < 2; i++) begin
        m_press[i] <= 1'b0;
        m_rel[i]   <= 1'b0;
        m_long[i]  <= 1'b0;
        if (m_d2[i] != m_val[i]) begin
          if (m_diff[i] == CNT_MAX) begin
            m_val[i]  <= m_d2[i];
            m_diff[i] <= 0;
            if (m_d2[i] == 1'b0) begin
              m_press[i] <= 1'b1;
              m_held[i]  <= 0;
            end else begin
              m_rel[i] <= 1'b1;
            end
          end else begin
            m_diff[i] <= m_diff[i] + 1;
          end
        end else begin
          m_diff[i] <= 0;
        end
        if (m_val[i] == 1'b0 && m_diff[i] == 0 && m_held[i] < LONG_MAX) begin
          m_held[i] <= m_held[i] + 1;
          if (m_held[i] == LONG_MAX - 1) m_long[i] <= 1'b1;
        end
      end
    end
  end

  int press_cnt [2];
  int rel_cnt   [2];
  int long_cnt  [2];
  initial for (int i = 0; i < 2; i++) begin
    press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      checks++;
      if ({key_value, key_press, key_release, key_long} !== {m_val, m_press, m_rel, m_long}) begin
        errors++;
        $display("FAIL model t=%0t: val/press/rel/long got %b/%b/%b/%b expected %b/%b/%b/%b",
                 $time, key_value, key_press, key_release, key_long, m_val, m_press, m_rel, m_long);
      end
      for (int i = 0; i < 2; i++) begin
        if (key_press[i])   press_cnt[i]++;
        if (key_release[i]) rel_cnt[i]++;
        if (key_long[i])    long_cnt[i]++;
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  // which: 0 = press, 1 = release, 2 = long. k = steps taken until the pulse.
  task automatic wait_out(input int which, input int idx, input int limit,
                          input string name, output int k);
    logic [1:0] v;
    bit done;
    k = 0;
    done = 1'b0;
    while (!done) begin
      step();
      k++;
      v = (which == 0) ? key_press : (which == 1) ? key_release : key_long;
      if (v[idx]) begin
        done = 1'b1;
      end else if (k >= limit) begin
        checks++;
        errors++;
        $display("FAIL %s: no pulse within %0d cycles", name, limit);
        done = 1'b1;
      end
    end
  endtask

  int k, p0, r0, l0, p1, r1, l1;

  initial begin
    // 1. key held low through reset
    sys_rst_n = 1'b0;
    key = 2'b00;
    step();
    chk_en = 1'b1;
    repeat (9) step();
    check("reset_value", 32'(key_value), 32'd3);
    check("reset_press", 32'(key_press), 32'd0);
    sys_rst_n = 1'b1;
    repeat (7) step();
    check("rst_press_early", 32'(key_press), 32'd0);
    step();
    check("rst_press_at7", 32'(key_press), 32'd3);
    check("rst_value_low", 32'(key_value), 32'd0);
    step();
    check("rst_press_1cyc", 32'(key_press), 32'd0);
    key = 2'b11;
    repeat (40) step();
    check("t1_released", 32'(key_value), 32'd3);

    // 2. glitches on key[0]
    p0 = press_cnt[0];
    for (int g = 0; g < 3; g++) begin
      key[0] = 1'b0; repeat (3) step();
      key[0] = 1'b1; repeat (3) step();
    end
    check("glitch_no_press", 32'(press_cnt[0] - p0), 32'd0);
    key[0] = 1'b0;
    wait_out(0, 0, 30, "glitch_press", k);
    check("glitch_latency", 32'(k), 32'd8);
    repeat (5) step();
    check("glitch_one_press", 32'(press_cnt[0] - p0), 32'd1);
    key[0] = 1'b1;
    repeat (15) step();

    // 3. key[1] long press
    l1 = long_cnt[1];
    key[1] = 1'b0;
    wait_out(0, 1, 30, "long_press", k);
    wait_out(2, 1, 40, "long_fire", k);
    check("long_after_press", 32'(k), 32'd20);
    repeat (2) step();
    key[1] = 1'b1;
    wait_out(1, 1, 30, "long_release", k);
    check("release_latency", 32'(k), 32'd8);
    check("long_once", 32'(long_cnt[1] - l1), 32'd1);
    step();
    check("t3_value", 32'(key_value), 32'd3);

    // 4. alternating keys
    p0 = press_cnt[0]; r0 = rel_cnt[0]; p1 = press_cnt[1]; r1 = rel_cnt[1];
    key = 2'b11; repeat (50) step();
    key = 2'b10; repeat (50) step();
    key = 2'b11; repeat (50) step();
    key = 2'b01; repeat (50) step();
    key = 2'b11; repeat (20) step();
    check("alt_press0", 32'(press_cnt[0] - p0), 32'd1);
    check("alt_rel0", 32'(rel_cnt[0] - r0), 32'd1);
    check("alt_press1", 32'(press_cnt[1] - p1), 32'd1);
    check("alt_rel1", 32'(rel_cnt[1] - r1), 32'd1);

    // 5. reset during PRESS_FILT
    p0 = press_cnt[0];
    key[0] = 1'b0;
    repeat (3) step();
    sys_rst_n = 1'b0;
    repeat (3) step();
    check("rst_abort_none", 32'(press_cnt[0] - p0), 32'd0);
    sys_rst_n = 1'b1;
    wait_out(0, 0, 30, "rst_abort_press", k);
    check("rst_abort_latency", 32'(k), 32'd8);
    key[0] = 1'b1;
    repeat (15) step();

    // 6. both keys on the same edge
    key = 2'b00;
    wait_out(0, 0, 30, "both_press", k);
    check("both_press_vec", 32'(key_press), 32'd3);
    repeat (10) step();
    key = 2'b11;
    wait_out(1, 0, 30, "both_release", k);
    check("both_release_vec", 32'(key_release), 32'd3);
    repeat (5) step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
